// File: rtl/crypto_key_loader_pkg.sv
// Shared SoC definitions for the crypto key loader: key-register address map,
// target table and loader FSM state encoding.
// Optional macro CRYPTO_KEY_LOADER_VERIFY_EN adds the readback states.
package ariane_soc;

  // Key-register blocks on the peripheral register bus.
  localparam logic [63:0] AES0Base = 64'h0000_00ff_f520_0000;
  localparam logic [63:0] AES1Base = 64'h0000_00ff_f520_1000;
  localparam logic [63:0] AES2Base = 64'h0000_00ff_f520_2000;
  localparam logic [63:0] HMACBase = 64'h0000_00ff_f520_3000;

  // First word of each key register; words are 64-bit aligned, 8 bytes apart.
  localparam logic [63:0] AES0Key0_0 = AES0Base + 64'h28;
  localparam logic [63:0] AES0Key1_0 = AES0Base + 64'h58;
  localparam logic [63:0] AES0Key2_0 = AES0Base + 64'h88;
  localparam logic [63:0] AES1Key0_0 = AES1Base + 64'h28;
  localparam logic [63:0] AES1Key1_0 = AES1Base + 64'h68;
  localparam logic [63:0] AES1Key2_0 = AES1Base + 64'ha8;
  localparam logic [63:0] AES2Key0_0 = AES2Base + 64'h28;
  localparam logic [63:0] AES2Key1_0 = AES2Base + 64'h48;
  localparam logic [63:0] AES2Key2_0 = AES2Base + 64'h68;
  localparam logic [63:0] HMACKey_0  = HMACBase + 64'hd0;

  // Load order of the key targets.
  typedef enum logic [3:0] {
    TGT_AES0_KEY0 = 4'd0,
    TGT_AES0_KEY1 = 4'd1,
    TGT_AES0_KEY2 = 4'd2,
    TGT_AES1_KEY0 = 4'd3,
    TGT_AES1_KEY1 = 4'd4,
    TGT_AES1_KEY2 = 4'd5,
    TGT_AES2_KEY0 = 4'd6,
    TGT_AES2_KEY1 = 4'd7,
    TGT_AES2_KEY2 = 4'd8,
    TGT_HMAC_KEY  = 4'd9
  } key_tgt_t;

  localparam int unsigned NumKeyTgts   = 10;
  localparam int unsigned KeyLoadWords = 62;

  localparam logic [63:0] KeyTgtBase [NumKeyTgts] = '{
    AES0Key0_0, AES0Key1_0, AES0Key2_0,
    AES1Key0_0, AES1Key1_0, AES1Key2_0,
    AES2Key0_0, AES2Key1_0, AES2Key2_0,
    HMACKey_0
  };

  localparam logic [3:0] KeyTgtWords [NumKeyTgts] = '{
    4'd6, 4'd6, 4'd6,
    4'd8, 4'd8, 4'd8,
    4'd4, 4'd4, 4'd4,
    4'd8
  };

  // Loader FSM states; readback states exist only in the verify build.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FETCH = 4'd1,
    ST_FWAIT = 4'd2,
    ST_WREQ  = 4'd3,
    ST_WRESP = 4'd4,
    ST_DONE  = 4'd5,
    ST_ERROR = 4'd6
`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
    ,
    ST_VREQ  = 4'd7,
    ST_VRESP = 4'd8
`endif
  } kl_state_t;

endpackage

// File: rtl/crypto_key_loader_timeout.sv
// key_loader_timeout: loadable down-counter guarding the bus wait states.
// Loaded with Cycles-1 on every state entry, counts down while enabled; the
// expiry flag marks the Cycles-th consecutive enabled cycle.
module key_loader_timeout #(
  parameter int unsigned Cycles = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Cycles > 2) ? $clog2(Cycles) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: reload on state entry, otherwise count down to zero while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= LoadVal;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/crypto_key_loader.sv
// crypto_key_loader: boot-time sequencer that copies 62 fuse words into the
// AES0/AES1/AES2/HMAC key registers over the peripheral register bus.
// Optional macro CRYPTO_KEY_LOADER_VERIFY_EN adds a readback compare of every
// written word. Bus handshake: a request is held with stable address/data until
// bus_gnt_i is sampled high; one response (bus_rvalid_i) follows each grant no
// earlier than the next cycle; responses outside the response states are ignored.
module crypto_key_loader
  import ariane_soc::*;
#(
  parameter int unsigned FuseAddrWidth = 7,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [3:0]               err_tgt_o,
  output logic                     fuse_req_o,
  output logic [FuseAddrWidth-1:0] fuse_addr_o,
  input  logic [31:0]              fuse_rdata_i,
  output logic                     bus_req_o,
  output logic                     bus_we_o,
  output logic [63:0]              bus_addr_o,
  output logic [31:0]              bus_wdata_o,
  input  logic                     bus_gnt_i,
  input  logic                     bus_rvalid_i,
  input  logic [31:0]              bus_rdata_i
);

  kl_state_t state_q, state_d;
  logic [3:0]               tgt_q, tgt_d;
  logic [3:0]               wcnt_q, wcnt_d;
  logic [FuseAddrWidth-1:0] fidx_q, fidx_d;
  logic [31:0]              word_q, word_d;

  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [3:0]               err_tgt_q, err_tgt_d;
  logic                     fuse_req_q, fuse_req_d;
  logic [FuseAddrWidth-1:0] fuse_addr_q, fuse_addr_d;
  logic                     bus_req_q, bus_req_d;
  logic                     bus_we_q, bus_we_d;
  logic [63:0]              bus_addr_q, bus_addr_d;
  logic [31:0]              bus_wdata_q, bus_wdata_d;

  logic advance;
  logic abort;
  logic tmo_load;
  logic tmo_en;
  logic tmo_expired;

  // Timeout runs only in bus wait states and restarts on every state change.
  assign tmo_load = (state_d != state_q);
`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
  assign tmo_en = (state_q == ST_WREQ) || (state_q == ST_WRESP) ||
                  (state_q == ST_VREQ) || (state_q == ST_VRESP);
`else
  assign tmo_en = (state_q == ST_WREQ) || (state_q == ST_WRESP);
`endif

  key_loader_timeout #(
    .Cycles (TimeoutCycles)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (tmo_load),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  // Next-state, counter, word-register and registered-output computation.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    wcnt_d    = wcnt_q;
    fidx_d    = fidx_q;
    word_d    = word_q;
    done_d    = done_q;
    error_d   = error_q;
    err_tgt_d = err_tgt_q;
    advance   = 1'b0;
    abort     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d   = ST_FETCH;
          tgt_d     = '0;
          wcnt_d    = '0;
          fidx_d    = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_tgt_d = '0;
        end
      end
      ST_FETCH: state_d = ST_FWAIT;
      ST_FWAIT: begin
        word_d  = fuse_rdata_i;
        state_d = ST_WREQ;
      end
      ST_WREQ: begin
        // A grant in the expiry cycle still wins.
        if (bus_gnt_i) begin
          state_d = ST_WRESP;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      ST_WRESP: begin
        if (bus_rvalid_i) begin
`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
          state_d = ST_VREQ;
`else
          advance = 1'b1;
`endif
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
      ST_VREQ: begin
        if (bus_gnt_i) begin
          state_d = ST_VRESP;
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
      ST_VRESP: begin
        if (bus_rvalid_i) begin
          if (bus_rdata_i == word_q) begin
            advance = 1'b1;
          end else begin
            abort = 1'b1;
          end
        end else if (tmo_expired) begin
          abort = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Step to the next word; the target counter stops at the last target.
    if (advance) begin
      fidx_d = fidx_q + FuseAddrWidth'(1);
      if (wcnt_q == (KeyTgtWords[tgt_q] - 4'd1)) begin
        wcnt_d = '0;
        if (tgt_q == TGT_HMAC_KEY) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          tgt_d   = tgt_q + 4'd1;
          state_d = ST_FETCH;
        end
      end else begin
        wcnt_d  = wcnt_q + 4'd1;
        state_d = ST_FETCH;
      end
    end

    if (abort) begin
      state_d   = ST_ERROR;
      error_d   = 1'b1;
      err_tgt_d = tgt_q;
    end

    // Key material does not linger once the sequence has ended.
    if ((state_d == ST_DONE) || (state_d == ST_ERROR)) begin
      word_d = '0;
    end

    busy_d      = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERROR));
    fuse_req_d  = (state_d == ST_FETCH);
    fuse_addr_d = (state_d == ST_FETCH) ? fidx_d : '0;
    bus_we_d    = (state_d == ST_WREQ);
`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
    bus_req_d   = (state_d == ST_WREQ) || (state_d == ST_VREQ);
`else
    bus_req_d   = (state_d == ST_WREQ);
`endif
    bus_addr_d  = bus_req_d ? (KeyTgtBase[tgt_d] + 64'({wcnt_d, 3'b000})) : '0;
    bus_wdata_d = (state_d == ST_WREQ) ? word_d : '0;
  end

  // FSM state, counters, word register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tgt_q       <= '0;
      wcnt_q      <= '0;
      fidx_q      <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_tgt_q   <= '0;
      fuse_req_q  <= 1'b0;
      fuse_addr_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      wcnt_q      <= wcnt_d;
      fidx_q      <= fidx_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_tgt_q   <= err_tgt_d;
      fuse_req_q  <= fuse_req_d;
      fuse_addr_q <= fuse_addr_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_tgt_o   = err_tgt_q;
  assign fuse_req_o  = fuse_req_q;
  assign fuse_addr_o = fuse_addr_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_crypto_key_loader.sv
// Testbench for crypto_key_loader: bus/fuse responder with a write scoreboard,
// table of full-sequence scenarios, plus timeout, mid-sequence reset and
// (with CRYPTO_KEY_LOADER_VERIFY_EN) readback-corruption sequences.
`timescale 1ns/1ps
module tb_crypto_key_loader;

  localparam int FAW    = 7;
  localparam int TMO    = 255;
  localparam int NWORDS = 62;
`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
  localparam int WORD_COST     = 6;
  localparam int REQS_PER_WORD = 2;
`else
  localparam int WORD_COST     = 4;
  localparam int REQS_PER_WORD = 1;
`endif

  logic           clk_i, rst_i, start_i;
  logic           busy_o, done_o, error_o;
  logic [3:0]     err_tgt_o;
  logic           fuse_req_o;
  logic [FAW-1:0] fuse_addr_o;
  logic [31:0]    fuse_rdata_i;
  logic           bus_req_o, bus_we_o;
  logic [63:0]    bus_addr_o;
  logic [31:0]    bus_wdata_o;
  logic           bus_gnt_i, bus_rvalid_i;
  logic [31:0]    bus_rdata_i;

  crypto_key_loader #(
    .FuseAddrWidth (FAW),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_tgt_o    (err_tgt_o),
    .fuse_req_o   (fuse_req_o),
    .fuse_addr_o  (fuse_addr_o),
    .fuse_rdata_i (fuse_rdata_i),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  // ---------------- clock / reset ----------------
  int cyc_cnt;
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end
  initial begin
    cyc_cnt = 0;
    forever begin
      @(posedge clk_i);
      cyc_cnt++;
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference address map of the key targets.
  function automatic logic [63:0] tgt_base(input int t);
    case (t)
      0: return 64'h0000_00ff_f520_0028;
      1: return 64'h0000_00ff_f520_0058;
      2: return 64'h0000_00ff_f520_0088;
      3: return 64'h0000_00ff_f520_1028;
      4: return 64'h0000_00ff_f520_1068;
      5: return 64'h0000_00ff_f520_10a8;
      6: return 64'h0000_00ff_f520_2028;
      7: return 64'h0000_00ff_f520_2048;
      8: return 64'h0000_00ff_f520_2068;
      default: return 64'h0000_00ff_f520_30d0;
    endcase
  endfunction

  function automatic int tgt_words(input int t);
    if (t < 3) return 6;
    if (t < 6) return 8;
    if (t < 9) return 4;
    return 8;
  endfunction

  function automatic logic [63:0] word_addr(input int idx);
    int rem = idx;
    for (int t = 0; t < 10; t++) begin
      if (rem < tgt_words(t)) return tgt_base(t) + 64'(8 * rem);
      rem -= tgt_words(t);
    end
    return '0;
  endfunction

  // Scoreboard: {address, data} of every write still expected.
  logic [95:0] exp_q[$];

  task automatic push_expected();
    exp_q.delete();
    for (int i = 0; i < NWORDS; i++) exp_q.push_back({word_addr(i), 32'hA5A5_0000 + 32'(i)});
  endtask

  // ---------------- fuse / bus responder ----------------
  int          stall_cycles = 0;
  int          stall_cnt    = 0;
  int          wr_count     = 0;
  int          drop_idx     = -1;
  int          corrupt_idx  = -1;
  int          drop_gnt_cyc = 0;
  bit          resp_pending = 0;
  bit          resp_drop    = 0;
  logic [31:0] resp_data;
  logic [63:0] held_addr, last_wr_addr;
  logic [31:0] last_wr_data;
  logic [95:0] exp_e;

  initial begin
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    fuse_rdata_i = '0;
    resp_data    = '0;
    forever begin
      @(negedge clk_i);
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = '0;
      if (fuse_req_o) fuse_rdata_i = 32'hA5A5_0000 + 32'(fuse_addr_o);
      if (!bus_req_o) chk("wdata_idle", 64'(bus_wdata_o), 64'd0);
      if (resp_pending) begin
        resp_pending = 0;
        if (!resp_drop) begin
          bus_rvalid_i = 1'b1;
          bus_rdata_i  = resp_data;
        end
      end else if (bus_req_o) begin
        if (stall_cnt == 0) held_addr = bus_addr_o;
        else chk("stall_addr", bus_addr_o, held_addr);
        if (stall_cnt < stall_cycles) begin
          stall_cnt++;
        end else begin
          stall_cnt    = 0;
          bus_gnt_i    = 1'b1;
          resp_pending = 1;
          resp_drop    = 0;
          resp_data    = '0;
          if (bus_we_o) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 64'd1, 64'd0);
            end else begin
              exp_e = exp_q.pop_front();
              chk("wr_addr", bus_addr_o, exp_e[95:32]);
              chk("wr_data", 64'(bus_wdata_o), 64'(exp_e[31:0]));
            end
            last_wr_addr = bus_addr_o;
            last_wr_data = bus_wdata_o;
            if (wr_count == drop_idx) begin
              resp_drop    = 1;
              drop_gnt_cyc = cyc_cnt;
            end
            wr_count++;
          end else begin
            chk("rd_addr", bus_addr_o, last_wr_addr);
            chk("rd_wdata", 64'(bus_wdata_o), 64'd0);
            resp_data = last_wr_data ^ (((wr_count - 1) == corrupt_idx) ? 32'h0000_0100 : 32'h0);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      64'(busy_o),      64'd0);
    chk({tag, "_done"},      64'(done_o),      64'd0);
    chk({tag, "_error"},     64'(error_o),     64'd0);
    chk({tag, "_err_tgt"},   64'(err_tgt_o),   64'd0);
    chk({tag, "_fuse_req"},  64'(fuse_req_o),  64'd0);
    chk({tag, "_fuse_addr"}, 64'(fuse_addr_o), 64'd0);
    chk({tag, "_bus_req"},   64'(bus_req_o),   64'd0);
    chk({tag, "_bus_we"},    64'(bus_we_o),    64'd0);
    chk({tag, "_bus_addr"},  bus_addr_o,       64'd0);
    chk({tag, "_bus_wdata"}, 64'(bus_wdata_o), 64'd0);
  endtask

  task automatic begin_seq(input int stall);
    push_expected();
    stall_cycles = stall;
    stall_cnt    = 0;
    wr_count     = 0;
    @(negedge clk_i);
    start_i = 1'b1;
  endtask

  // Full load; start_pulse (>0) re-pulses start_i in that cycle.
  task automatic run_seq(input int stall, input int start_pulse, input int exp_done);
    int cyc      = 0;
    int done_cyc = -1;
    begin_seq(stall);
    while (cyc < exp_done + 100) begin
      @(negedge clk_i);
      cyc++;
      start_i = (cyc == start_pulse);
      if (cyc == 1) begin
        chk("lat_fuse_req", 64'(fuse_req_o), 64'd1);
        chk("lat_fuse_addr", 64'(fuse_addr_o), 64'd0);
        chk("lat_busy", 64'(busy_o), 64'd1);
        chk("lat_done_clr", 64'(done_o), 64'd0);
        chk("lat_err_clr", 64'(error_o), 64'd0);
      end
      if (cyc == 3) chk("lat_bus_req", 64'(bus_req_o), 64'd1);
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    start_i = 1'b0;
    chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    chk("write_count", 64'(wr_count), 64'(NWORDS));
    chk("done_busy", 64'(busy_o), 64'd0);
    chk("done_error", 64'(error_o), 64'd0);
  endtask

  task automatic wait_error(input int bound, output int seen_cyc);
    seen_cyc = -1;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (error_o) begin
        seen_cyc = cyc_cnt;
        break;
      end
    end
    chk("error_seen", 64'(seen_cyc >= 0), 64'd1);
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int stall;
    int start_pulse;
    int exp_done;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int err_cyc;
    int cyc;

    vecs[0] = '{stall: 0,  start_pulse: 0,  exp_done: NWORDS * WORD_COST + 1};
    vecs[1] = '{stall: 10, start_pulse: 0,  exp_done: NWORDS * (WORD_COST + REQS_PER_WORD * 10) + 1};
    vecs[2] = '{stall: 0,  start_pulse: 50, exp_done: NWORDS * WORD_COST + 1};
    vecs[3] = '{stall: 3,  start_pulse: 0,  exp_done: NWORDS * (WORD_COST + REQS_PER_WORD * 3) + 1};

    rst_i   = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("idle");

    chk("first_addr", word_addr(0), 64'h0000_00ff_f520_0028);
    chk("last_addr", word_addr(NWORDS - 1), 64'h0000_00ff_f520_3108);

    for (int i = 0; i < 4; i++) run_seq(vecs[i].stall, vecs[i].start_pulse, vecs[i].exp_done);

    // Timeout: write response of target 3, word 0 never arrives.
    drop_idx = 18;
    begin_seq(0);
    wait_error(NWORDS * WORD_COST + TMO + 100, err_cyc);
    drop_idx = -1;
    chk("tmo_delay", 64'(err_cyc - drop_gnt_cyc), 64'(TMO + 1));
    chk("tmo_err_tgt", 64'(err_tgt_o), 64'd3);
    chk("tmo_wdata", 64'(bus_wdata_o), 64'd0);
    chk("tmo_bus_req", 64'(bus_req_o), 64'd0);
    chk("tmo_busy", 64'(busy_o), 64'd0);
    chk("tmo_done", 64'(done_o), 64'd0);
    repeat (5) @(negedge clk_i);
    chk("tmo_sticky", 64'(error_o), 64'd1);
    chk("tmo_writes", 64'(wr_count), 64'd19);

    // Reset in the middle of target 5 (start accepted from ERROR).
    begin_seq(0);
    cyc = 0;
    while ((wr_count < 36) && (cyc < 1000)) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      if (cyc == 1) chk("rst_err_clr", 64'(error_o), 64'd0);
    end
    chk("rst_reached_t5", 64'(wr_count >= 36), 64'd1);
    rst_i = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk_i);
    rst_i = 1'b0;
    check_all_zero("post_rst");
    repeat (3) @(negedge clk_i);
    chk("post_rst_no_req", 64'(bus_req_o), 64'd0);
    run_seq(0, 0, NWORDS * WORD_COST + 1);

`ifdef CRYPTO_KEY_LOADER_VERIFY_EN
    // Readback of target 7, word 2 comes back corrupted.
    corrupt_idx = 48;
    begin_seq(0);
    wait_error(NWORDS * WORD_COST + 100, err_cyc);
    corrupt_idx = -1;
    chk("vfy_err_tgt", 64'(err_tgt_o), 64'd7);
    chk("vfy_wdata", 64'(bus_wdata_o), 64'd0);
    repeat (10) @(negedge clk_i);
    chk("vfy_writes", 64'(wr_count), 64'd49);
    chk("vfy_left", 64'(exp_q.size()), 64'(NWORDS - 49));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crypto_key_loader.md
# crypto_key_loader

Boot-time key provisioning sequencer for the crypto peripheral cluster. On a start pulse it streams 32-bit key words from the on-die fuse array and writes each one to its key register on the peripheral register bus, using the key-register address map held in `ariane_soc`. It sits directly upstream of the AES0/AES1/AES2/HMAC key registers and downstream of the fuse controller. It reports completion or the first failing target to the boot controller.

## Interface
Parameters:
- `FuseAddrWidth`, default 7: fuse word address width; must hold the total word count, 62.
- `TimeoutCycles`, default 255: maximum wait cycles in any bus wait state before an error is raised.

Ports:
- `clk_i`, in, 1: clock. One clock domain only.
- `rst_i`, in, 1: reset. Asynchronous, active-high.
- `start_i`, in, 1: begin the load sequence. Sampled only in IDLE, DONE or ERROR.
- `busy_o`, out, 1: sequence in progress.
- `done_o`, out, 1: all targets loaded. Level signal, cleared by the next accepted start.
- `error_o`, out, 1: sequence aborted. Sticky until the next accepted start.
- `err_tgt_o`, out, 4: index of the target that failed. Valid while `error_o` is high.
- `fuse_req_o`, out, 1: fuse read strobe, 1 cycle wide.
- `fuse_addr_o`, out, FuseAddrWidth: fuse word index.
- `fuse_rdata_i`, in, 32: fuse data. Valid exactly 1 cycle after `fuse_req_o`.
- `bus_req_o`, out, 1: register-bus request. Held until `bus_gnt_i` is seen.
- `bus_we_o`, out, 1: 1 for write, 0 for read.
- `bus_addr_o`, out, 64: byte address.
- `bus_wdata_o`, out, 32: write data.
- `bus_gnt_i`, in, 1: request accepted this cycle.
- `bus_rvalid_i`, in, 1: response valid. Arrives at least 1 cycle after `bus_gnt_i`.
- `bus_rdata_i`, in, 32: read data. Valid while `bus_rvalid_i` is high.

## Operation
- Target table, indices 0..9, in this order:
  - AES0Key0_0, AES0Key1_0, AES0Key2_0: 6 words each.
  - AES1Key0_0, AES1Key1_0, AES1Key2_0: 8 words each.
  - AES2Key0_0, AES2Key1_0, AES2Key2_0: 4 words each.
  - HMACKey_0: 8 words.
  - Total: 62 words.
- Addressing:
  - Word w of target t is written to `base[t] + 8*w`. Computed as a 64-bit add; no wrap is possible.
  - Fuse index is a running counter 0..61, incremented once per word.
- FSM states: IDLE, FETCH, FWAIT, WREQ, WRESP, DONE, ERROR.
  - IDLE/DONE/ERROR → FETCH on `start_i`. This clears `done_o`, `error_o`, and both counters.
  - FETCH: assert `fuse_req_o`; go to FWAIT.
  - FWAIT: capture `fuse_rdata_i` into the word register; go to WREQ.
  - WREQ: drive `bus_req_o=1`, `bus_we_o=1`, the address and the word. Go to WRESP on `bus_gnt_i`.
  - WRESP: on `bus_rvalid_i`, advance the word and target counters.
    - Last word of the last target → DONE.
    - Otherwise → FETCH.
- `start_i` is ignored while busy.
- Word register:
  - Zeroed on entry to DONE or ERROR.
  - `bus_wdata_o` is 0 whenever `bus_req_o` is 0.
- Timeout:
  - Per-state counter, reset on each state entry.
  - Counts cycles spent in WREQ or WRESP.
  - Reaching TimeoutCycles → ERROR, with `err_tgt_o` set to the current target.
- `busy_o` is high in every state except IDLE, DONE and ERROR.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE.
- Reset asserted mid-sequence:
  - Immediate return to IDLE; the word register is cleared.
  - No further bus request is issued.
  - An outstanding bus response is ignored.
- Latency from start:
  - `start_i` sampled high at cycle 0 → `fuse_req_o` high at cycle 1.
  - First `bus_req_o` at cycle 3.
- Per-word cost: minimum 4 cycles (gnt in the first WREQ cycle, rvalid 1 cycle later).
- Full sequence at minimum latency: 248 cycles. `done_o` rises at cycle 249.
- Simultaneous `bus_gnt_i` and timeout expiry in the same cycle: the grant wins.
- `bus_rvalid_i` outside WRESP (and outside VRESP with verify on) is ignored.

## Configuration
- Macro: `CRYPTO_KEY_LOADER_VERIFY_EN`.
- Defined: readback verification is compiled in.
  - WRESP → VREQ, a read of the same address (`bus_we_o=0`, `bus_wdata_o=0`).
  - VREQ → VRESP on `bus_gnt_i`.
  - VRESP: if `bus_rdata_i` matches the word register, advance as WRESP does. On mismatch → ERROR.
  - Timeout applies to VREQ and VRESP.
  - Minimum per-word cost: 6 cycles; full sequence 372 cycles.
- Undefined: the VREQ and VRESP states and the comparator are not present.

## Structure
- `ariane_soc` package owns:
  - the `key_tgt_t` enum (10 entries);
  - the per-target base-address array, built from the existing Key `_0` constants;
  - the per-target word-count array;
  - the total word count `KeyLoadWords` = 62.
- One sub-module, `key_loader_timeout`: loadable down-counter with an expiry flag.
- The FSM, counters and address adder live in the top level.

## Test plan
- Ideal path: start with zero-wait bus, fuse word i = 0xA5A50000+i.
  - 62 writes in table order.
  - First address 0xfff5200028, last address 0xfff5203108.
  - `done_o` at cycle 249.
- Backpressure: hold `bus_gnt_i` low for 10 cycles on each request.
  - Writes and data are unchanged.
  - No timeout.
  - `bus_req_o` and the address stay stable while stalled.
- Timeout: never return `bus_rvalid_i` on target 3, word 0.
  - `error_o`=1 and `err_tgt_o`=3 after 255 cycles.
  - Word register cleared, `bus_wdata_o`=0.
- Reset mid-op: assert `rst_i` during target 5.
  - All outputs go to 0.
  - A new start reloads from fuse index 0.
- Verify (with macro): corrupt the readback of target 7, word 2.
  - `error_o`=1, `err_tgt_o`=7.
  - No further writes are issued.
- Start while busy: pulse `start_i` at cycle 50.
  - Ignored; the sequence continues and completes unchanged.
